// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency MULT/DIV sequencing,
// HI/LO register file, MTHI/MTLO writes and hazard stall request.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_pwr;
  logic        r_done;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_is_mthi;
  logic        w_is_mtlo;

  assign w_is_mul  = (op == 3'd0) | (op == 3'd1);
  assign w_is_div  = (op == 3'd2) | (op == 3'd3);
  assign w_is_mthi = (op == 3'd4);
  assign w_is_mtlo = (op == 3'd5);

  // Multiplier: sign-extend for MULT, zero-extend for MULTU.
  logic        w_msgn;
  logic [63:0] w_ma;
  logic [63:0] w_mb;
  logic [63:0] w_prod;

  assign w_msgn = ~op[0];
  assign w_ma   = {{32{w_msgn & rs_val[31]}}, rs_val};
  assign w_mb   = {{32{w_msgn & rt_val[31]}}, rt_val};
  assign w_prod = w_ma * w_mb;

  // Divider works on magnitudes; signs are reapplied afterwards.
  logic        w_dsgn;
  logic        w_aneg;
  logic        w_bneg;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_dz;

  assign w_dsgn = ~op[0];
  assign w_aneg = w_dsgn & rs_val[31];
  assign w_bneg = w_dsgn & rt_val[31];
  assign w_amag = w_aneg ? (~rs_val + 32'd1) : rs_val;
  assign w_bmag = w_bneg ? (~rt_val + 32'd1) : rt_val;
  assign w_dz   = (rt_val == 32'd0);
  assign w_uq   = w_dz ? 32'd0 : (w_amag / w_bmag);
  assign w_ur   = w_dz ? 32'd0 : (w_amag % w_bmag);
  assign w_quo  = (w_aneg ^ w_bneg) ? (~w_uq + 32'd1) : w_uq;
  assign w_rem  = w_aneg ? (~w_ur + 32'd1) : w_ur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pwr   <= 1'b0;
      r_done  <= 1'b0;
    end else if (cancel) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            unique case (1'b1)
              w_is_mul: begin
                r_phi   <= w_prod[63:32];
                r_plo   <= w_prod[31:0];
                r_pwr   <= 1'b1;
                r_cnt   <= CW'(MULT_LAT);
                r_state <= S_MUL;
              end
              w_is_div: begin
                r_phi   <= w_rem;
                r_plo   <= w_quo;
                r_pwr   <= ~w_dz;
                r_cnt   <= CW'(DIV_LAT);
                r_state <= S_DIV;
              end
              w_is_mthi: r_hi <= rs_val;
              w_is_mtlo: r_lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            if (r_pwr) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign stall_req = d_md_use & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: arithmetic reference model plus
// directed scenarios with hand-computed results.
module tb_mdu_ctrl;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        cancel = 1'b0;
  logic        d_md_use = 1'b0;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic logic [63:0] f_mul(input logic sgn,
      input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    p = x * y;
    return 64'(p);
  endfunction

  function automatic logic [63:0] f_div(input logic sgn,
      input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: remaining busy cycles, pending result, architectural HI/LO.
  int          m_rem;
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  logic        m_pwr, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0;
      m_ph <= '0; m_pl <= '0; m_pwr <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (cancel) begin
        m_rem <= 0;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          if (m_pwr) begin
            m_hi <= m_ph;
            m_lo <= m_pl;
          end
          m_done <= 1'b1;
        end
      end else if (start) begin
        case (op)
          3'd0, 3'd1: begin
            {m_ph, m_pl} <= f_mul(op == 3'd0, rs_val, rt_val);
            m_pwr <= 1'b1;
            m_rem <= ML;
          end
          3'd2, 3'd3: begin
            if (rt_val != 0) {m_ph, m_pl} <= f_div(op == 3'd2, rs_val, rt_val);
            m_pwr <= (rt_val != 0);
            m_rem <= DL;
          end
          3'd4: m_hi <= rs_val;
          3'd5: m_lo <= rs_val;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 64'(busy), 64'(m_rem > 0));
    chk("cyc_done", 64'(done), 64'(m_done));
    chk("cyc_hi", 64'(hi), 64'(m_hi));
    chk("cyc_lo", 64'(lo), 64'(m_lo));
    chk("cyc_stall", 64'(stall_req),
        64'(d_md_use & ((m_rem > 0) | (start & (op <= 3'd3)))));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0; op = 3'd7;
  endtask

  // Count busy cycles (including the current one) until busy falls.
  task automatic wait_idle(input string name, input int lat);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk({name, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic run_op(input string name, input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b, input int lat,
      input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, a, b);
    wait_idle(name, lat);
    #1;
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
    tick();
    #1;
    chk({name, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    int k;
    repeat (3) tick();
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, ML, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("divu", 3'd3, 32'd100, 32'd7, DL, 32'd2, 32'd14);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DL, 32'd0, 32'h80000000);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, ML, 32'hFFFFFFFE, 32'd1);

    d_md_use = 1'b1;
    start = 1'b1; op = 3'd0; rs_val = 32'd4; rt_val = 32'd5;
    #1;
    chk("stall_start", 64'(stall_req), 64'd1);
    tick();
    start = 1'b0; op = 3'd7;
    for (int i = 0; i < ML; i++) begin
      #1;
      chk("stall_busy", 64'(stall_req), 64'd1);
      tick();
    end
    #1;
    chk("stall_end", 64'(stall_req), 64'd0);
    chk("stall_lo", 64'(lo), 64'd20);
    d_md_use = 1'b0;
    tick();

    issue(3'd4, 32'h1234, 32'd0);
    #1;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'h5678, 32'd0);
    #1;
    chk("mtlo_lo", 64'(lo), 64'h5678);
    tick();
    #1;
    chk("mt_nodone", 64'(done), 64'd0);

    run_op("divz", 3'd2, 32'd99, 32'd0, DL, 32'h1234, 32'h5678);

    issue(3'd1, 32'd3, 32'd5);
    tick();
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    #1;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hi", 64'(hi), 64'h1234);
    chk("cancel_lo", 64'(lo), 64'h5678);
    tick();
    #1;
    chk("cancel_nodone", 64'(done), 64'd0);

    cancel = 1'b1;
    issue(3'd0, 32'd7, 32'd7);
    cancel = 1'b0;
    #1;
    chk("cancel_win", 64'(busy), 64'd0);
    run_op("after_cancel", 3'd0, 32'd2, 32'd3, ML, 32'd0, 32'd6);

    issue(3'd3, 32'd100, 32'd7);
    issue(3'd0, 32'd9, 32'd9);
    wait_idle("ignored", DL - 1);
    #1;
    chk("ignored_hi", 64'(hi), 64'd2);
    chk("ignored_lo", 64'(lo), 64'd14);
    tick();

    issue(3'd6, 32'hDEAD, 32'hBEEF);
    #1;
    chk("nop_busy", 64'(busy), 64'd0);
    chk("nop_hi", 64'(hi), 64'd2);

    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    tick();
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (done) k++;
      tick();
    end
    chk("rstmid_nodone", 64'(k), 64'd0);
    chk("rstmid_lo_end", 64'(lo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter: MULT_LAT, 5, busy cycles for MULT/MULTU.
REQ-002 Parameter: DIV_LAT, 10, busy cycles for DIV/DIVU.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  E-stage MDU instruction valid this cycle.
REQ-007 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 no-op.
REQ-008 rs_val  in  32  forwarded rs operand.
REQ-009 rt_val  in  32  forwarded rt operand.
REQ-010 cancel  in  1  synchronous abort of in-flight operation (pipeline flush).
REQ-011 d_md_use  in  1  D-stage instruction is any MDU instruction (including MFHI/MFLO).
REQ-012 busy  out  1  operation in flight.
REQ-013 stall_req  out  1  stall request to the hazard unit.
REQ-014 done  out  1  one-cycle pulse after HI/LO are updated by mult/div.
REQ-015 hi  out  32  HI register.
REQ-016 lo  out  32  LO register.

Function
REQ-017 The FSM SHALL have states IDLE, MUL, DIV; busy SHALL be 1 exactly when the state is not IDLE.
REQ-018 In IDLE, start with op 0/1 SHALL capture the product into pending registers, load cnt=MULT_LAT, and enter MUL at that edge.
REQ-019 In IDLE, start with op 2/3 SHALL capture quotient and remainder, load cnt=DIV_LAT, and enter DIV at that edge.
REQ-020 In MUL/DIV, cnt SHALL decrement each edge; at the edge where cnt==1, hi/lo SHALL load the pending values, the state SHALL return to IDLE, and done SHALL be 1 for the following cycle.
REQ-021 busy SHALL therefore be high for exactly LAT cycles after the start edge; new hi/lo SHALL be visible on the cycle busy falls.
REQ-022 MULT SHALL form a signed 64-bit product; MULTU SHALL form an unsigned 64-bit product; hi = bits 63:32 and lo = bits 31:0.
REQ-023 DIV/DIVU SHALL set lo = quotient and hi = remainder; signed division truncates toward zero, and the remainder takes the sign of the dividend.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-025 Divide by zero SHALL still occupy DIV_LAT cycles, leave hi/lo unchanged, and pulse done.
REQ-026 MTHI/MTLO in IDLE SHALL write rs_val to hi/lo at the start edge, with no busy and no done.
REQ-027 start while busy SHALL be ignored, with no state, count or operand change; stall_req makes this unreachable in legal use.
REQ-028 stall_req SHALL be the combinational value d_md_use & (busy | (start & op<=3)).
REQ-029 cancel SHALL force IDLE and cnt=0, leave hi/lo unchanged, and suppress done.
REQ-030 cancel and start in the same cycle: cancel SHALL win and start SHALL be discarded.
REQ-031 Ops 6–7 with start SHALL have no effect.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, and clear the pending registers.
REQ-033 Reset asserted mid-operation SHALL discard the operation, with no hi/lo update and no done after release.
REQ-034 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 MULT rs=0xFFFFFFFE (−2), rt=3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done for 1 cycle.
REQ-036 DIVU rs=100, rt=7 -> busy for 10 cycles; then lo=14, hi=2; DIV rs=−7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 MULT start with d_md_use=1 on every cycle -> stall_req high on the start cycle and the next 5 cycles, then low once busy=0.
REQ-038 DIV rt=0 after MTHI 0x1234 / MTLO 0x5678 -> 10 busy cycles, done pulses, hi=0x1234, lo=0x5678.
REQ-039 cancel on 3rd busy cycle of MULTU -> busy=0 next cycle, hi/lo unchanged, no done; a following start is accepted.
REQ-040 rst_n low during DIV cycle 4 -> immediate busy=0, hi=lo=0; no done after release.
